// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the execute-stage iterative multiply/divide unit:
// opcode encodings, FSM state encoding and default operand width.
package ex_muldiv_unit_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FIXUP = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit_muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring subtract-compare for divide. Purely combinational.
module ex_muldiv_unit_muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [2*XLEN-1:0] mcand,
   input  logic [XLEN-1:0]   mplier,
   output logic [2*XLEN-1:0] acc_nx,
   output logic [2*XLEN-1:0] mcand_nx,
   output logic [XLEN-1:0]   mplier_nx
);

   // Divide keeps {remainder, dividend/quotient} in acc; the top XLEN+1 bits
   // are the partial remainder with the next dividend bit shifted in.
   logic [XLEN:0]   rem_top;
   logic            rem_ge;
   logic [XLEN-1:0] sub_res;

   assign rem_top = acc[2*XLEN-1:XLEN-1];
   assign rem_ge  = (rem_top >= {1'b0, mplier});
   assign sub_res = XLEN'(rem_top - {1'b0, mplier});

   always_comb begin
      acc_nx    = acc;
      mcand_nx  = mcand;
      mplier_nx = mplier;
      if (is_div) begin
         if (rem_ge) begin
            acc_nx = {sub_res, acc[XLEN-2:0], 1'b1};
         end else begin
            acc_nx = {rem_top[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_nx    = acc + (mplier[0] ? mcand : '0);
         mcand_nx  = {mcand[2*XLEN-2:0], 1'b0};
         mplier_nx = {1'b0, mplier[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers and stall request.
// Optional MULDIV_EARLY_TERM_EN: multiplies finish once the remaining multiplier is zero.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   input  logic            mf_req,
   input  logic            mthi,
   input  logic            mtlo,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done,
   output logic            stall_out
);

   localparam int               CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   function automatic logic [XLEN-1:0] abs_op(input logic signed [XLEN-1:0] v,
                                              input logic sgn);
      if (sgn && (v < 0)) begin
         return -v;
      end
      return v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   muldiv_state_t     state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              load, step_en, fix_en, early_stop;

   logic [2*XLEN-1:0] acc, mcand, acc_nx, mcand_nx;
   logic [XLEN-1:0]   mplier, mplier_nx, opa_raw;
   logic              is_div, neg_q, neg_r, div_zero;

   logic              is_div_in, sgn_in;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN-1:0]   hi_res, lo_res;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix;

   assign is_div_in = (op == OP_DIV) || (op == OP_DIVU);
   assign sgn_in    = (op == OP_MULT) || (op == OP_DIV);
   assign abs_a     = abs_op(opa, sgn_in);
   assign abs_b     = abs_op(opb, sgn_in);

   assign busy      = (state != S_IDLE);
   assign stall_out = busy & (start | mf_req | mthi | mtlo);

`ifdef MULDIV_EARLY_TERM_EN
   assign early_stop = !is_div && (mplier == '0);
`else
   assign early_stop = 1'b0;
`endif

   ex_muldiv_unit_muldiv_step #(
      .XLEN(XLEN)
   ) u_step (
      .is_div   (is_div),
      .acc      (acc),
      .mcand    (mcand),
      .mplier   (mplier),
      .acc_nx   (acc_nx),
      .mcand_nx (mcand_nx),
      .mplier_nx(mplier_nx)
   );

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step_en  = 1'b0;
      fix_en   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (early_stop) begin
               state_nx = S_FIXUP;
            end else begin
               step_en = 1'b1;
               if (cnt == CNT_LAST) begin
                  state_nx = S_FIXUP;
               end
            end
         end
         S_FIXUP: begin
            fix_en   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Sign correction and divide-by-zero override applied in FIXUP
   assign prod_fix = neg_wide(acc, neg_q);
   assign quot_fix = neg_word(acc[XLEN-1:0], neg_q);
   assign rem_fix  = neg_word(acc[2*XLEN-1:XLEN], neg_r);

   always_comb begin
      hi_res = prod_fix[2*XLEN-1:XLEN];
      lo_res = prod_fix[XLEN-1:0];
      if (is_div) begin
         if (div_zero) begin
            hi_res = opa_raw;
            lo_res = '1;
         end else begin
            hi_res = rem_fix;
            lo_res = quot_fix;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt  <= '0;
         done <= 1'b0;
         hi   <= '0;
         lo   <= '0;
      end else begin
         done <= fix_en;
         if (load) begin
            cnt <= '0;
         end else if (step_en) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (fix_en) begin
            hi <= hi_res;
            lo <= lo_res;
         end else if ((state == S_IDLE) && !start) begin
            if (mthi) hi <= opa;
            if (mtlo) lo <= opa;
         end
      end
   end

   // Operand datapath: not reset, only meaningful after a load
   always_ff @(posedge clock) begin
      if (load) begin
         opa_raw  <= opa;
         is_div   <= is_div_in;
         neg_q    <= sgn_in & (opa[XLEN-1] ^ opb[XLEN-1]);
         neg_r    <= sgn_in & opa[XLEN-1];
         div_zero <= (opb == '0);
         acc      <= is_div_in ? {{XLEN{1'b0}}, abs_a} : '0;
         mcand    <= {{XLEN{1'b0}}, abs_a};
         mplier   <= abs_b;
      end else if (step_en) begin
         acc    <= acc_nx;
         mcand  <= mcand_nx;
         mplier <= mplier_nx;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: arithmetic reference model plus directed vectors.
// Build with or without MULDIV_EARLY_TERM_EN; expected multiply latencies follow the define.
module tb_ex_muldiv_unit;

   localparam logic [1:0] T_MULT = 2'b00, T_MULTU = 2'b01, T_DIV = 2'b10, T_DIVU = 2'b11;
`ifdef MULDIV_EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] opa = '0, opb = '0;
   logic        mf_req = 1'b0, mthi = 1'b0, mtlo = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, done, stall_out;

   int checks = 0;
   int errors = 0;

   ex_muldiv_unit dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .opa      (opa),
      .opb      (opb),
      .mf_req   (mf_req),
      .mthi     (mthi),
      .mtlo     (mtlo),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .stall_out(stall_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference result and latency from plain arithmetic on the operands.
   function automatic void calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl, output int lat);
      longint      sa, sb, q, r;
      logic [63:0] p;
      logic [31:0] m;
      int          k;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lat = 33;
      rh  = '0;
      rl  = '0;
      case (o)
         T_MULT:  begin p = sa * sb; {rh, rl} = p; end
         T_MULTU: begin p = {32'b0, a} * {32'b0, b}; {rh, rl} = p; end
         T_DIV: begin
            if (b == 0) begin rh = a; rl = '1; end
            else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
         end
         default: begin
            if (b == 0) begin rh = a; rl = '1; end
            else begin rl = a / b; rh = a % b; end
         end
      endcase
      if (ET && (o[1] == 1'b0)) begin
         m = (o == T_MULT && b[31]) ? -b : b;
         k = 0;
         for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
         lat = (k == 32) ? 33 : k + 2;
      end
   endfunction

   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_busy, m_done;
   int          m_rem;
   bit          chk_en = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; chk_en = 1'b1;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
         end else if (start) begin
            calc(op, opa, opb, p_hi, p_lo, m_rem);
            m_busy = 1'b1;
         end else begin
            if (mthi) m_hi = opa;
            if (mtlo) m_lo = opa;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
         chk("busy", {31'b0, busy}, {31'b0, m_busy});
         chk("done", {31'b0, done}, {31'b0, m_done});
         chk("stall", {31'b0, stall_out},
             {31'b0, m_busy & (start | mf_req | mthi | mtlo)});
      end
   end

   task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic mv, input logic [31:0] eh,
                        input logic [31:0] el, input int elat);
      int n, bc;
      @(posedge clock); #2;
      start = 1'b1; op = o; opa = a; opb = b; mthi = mv;
      @(posedge clock); #2;
      start = 1'b0; mthi = 1'b0;
      bc = busy ? 1 : 0;
      n  = 0;
      do begin
         @(posedge clock); #1;
         n++;
         if (busy) bc++;
      end while (!done && n < 100);
      chk({nm, "_lat"}, n, elat);
      chk({nm, "_busy_cycles"}, bc, elat);
      chk({nm, "_hi"}, hi, eh);
      chk({nm, "_lo"}, lo, el);
   endtask

   initial begin
      logic [31:0] th, tl;
      int          tlat, n;
      bit          saw_done;

      // Pin the reference model against hand-computed results
      calc(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, th, tl, tlat);
      chk("model_multu_hi", th, 32'hFFFF_FFFE);
      chk("model_multu_lo", tl, 32'h0000_0001);
      calc(T_DIV, 32'hFFFF_FFEF, 32'd5, th, tl, tlat);
      chk("model_div_hi", th, 32'hFFFF_FFFE);
      chk("model_div_lo", tl, 32'hFFFF_FFFD);

      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);

      do_op("multu_ff", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1, 33);
      do_op("mult_neg", T_MULT, 32'hFFFF_FFF9, 32'd6, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFD6,
            ET ? 5 : 33);
      do_op("div_neg", T_DIV, 32'hFFFF_FFEF, 32'd5, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      do_op("divu_zero", T_DIVU, 32'd100, 32'd0, 1'b0, 32'd100, 32'hFFFF_FFFF, 33);
      do_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 33);
      do_op("div_zero_s", T_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);
      do_op("multu_zero", T_MULTU, 32'd1234, 32'd0, 1'b0, 32'h0, 32'h0, ET ? 2 : 33);
      do_op("multu_small", T_MULTU, 32'd5, 32'd3, 1'b0, 32'h0, 32'd15, ET ? 4 : 33);
      do_op("div_negb", T_DIV, 32'd17, 32'hFFFF_FFFB, 1'b0, 32'd2, 32'hFFFF_FFFD, 33);

      // Reads and moves arriving while busy must stall and be ignored
      @(posedge clock); #2;
      start = 1'b1; op = T_MULT; opa = 32'd3; opb = 32'h4000_0000;
      @(posedge clock); #2;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #2;
      mf_req = 1'b1; mthi = 1'b1; opa = 32'hDEAD_BEEF;
      n = 4;
      do begin
         @(posedge clock); #1;
         n++;
         if (n == 10) begin
            chk("mf_stall_mid", {31'b0, stall_out}, 32'h1);
            chk("mf_hi_held", hi, 32'd2);
            chk("mf_lo_held", lo, 32'hFFFF_FFFD);
         end
         if (n == 20) mthi = 1'b0;
      end while (!done && n < 100);
      chk("mf_lat", n, 33);
      chk("mf_stall_done", {31'b0, stall_out}, 32'h0);
      chk("mf_hi", hi, 32'h0);
      chk("mf_lo", lo, 32'hC000_0000);
      #1 mf_req = 1'b0;

      // Reset in the middle of a divide aborts it and clears HI/LO
      @(posedge clock); #2;
      start = 1'b1; op = T_DIV; opa = 32'd1000; opb = 32'd7;
      @(posedge clock); #2;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #2 reset = 1'b1;
      @(posedge clock); #1;
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      #1 reset = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clock); #1;
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", {31'b0, saw_done}, 32'h0);

      #1 mthi = 1'b1; opa = 32'h0000_1234;
      @(posedge clock); #1;
      chk("mthi_hi", hi, 32'h0000_1234);
      #1 mthi = 1'b0; mtlo = 1'b1; opa = 32'h0000_5678;
      @(posedge clock); #1;
      chk("mtlo_lo", lo, 32'h0000_5678);
      chk("mtlo_hi_kept", hi, 32'h0000_1234);
      #1 mtlo = 1'b0;

      // start together with mthi: the move is dropped
      do_op("start_mthi", T_MULTU, 32'd2, 32'd3, 1'b1, 32'h0, 32'd6, ET ? 4 : 33);

      repeat (3) @(posedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

endmodule
